_add32_arbiter: RTL
===================

# _add32_arbiter

Shares one `_add32` ripple adder, built from eight `_74x283` slices, among N requesters, such as PC increment, branch target and load/store address. Each requester uses a valid/ready handshake. The block grants one requester at a time and registers its operands. It then allows one full cycle for the carry chain to settle and returns the registered sum with the requester's ID on a single response channel. Only one transaction is in flight at a time.

## Interface
- `N`, default 4: number of requesters, legal range 2..8.
- `ID_W`, default `$clog2(N)`: localparam, width of the requester ID.
- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input N: bit i means requester i presents operands.
- `req_ready` output N: one-hot grant; a handshake completes on a cycle where `req_valid[i] & req_ready[i]`.
- `req_a` input N*32: operand A; requester i uses bits [i*32+31:i*32].
- `req_b` input N*32: operand B, packed the same way as `req_a`.
- `rsp_valid` output 1: response holds a sum.
- `rsp_ready` input 1: consumer accepts the response.
- `rsp_id` output ID_W: index of the requester that owns the sum.
- `rsp_sum` output 32: (a + b) mod 2^32; no carry-out is available.
- `busy` output 1: high in any state other than IDLE.

## Operation
- The FSM has three states: IDLE, EXEC and DONE. The reset state is IDLE.
- IDLE:
  - If any `req_valid` bit is high, grant exactly one requester g.
  - `req_ready[g]` is driven combinationally, only in IDLE.
  - On the clock edge, latch `req_a[g]`, `req_b[g]` and g into the operand/ID registers, update the priority pointer, then go to EXEC.
  - If no request is valid, stay in IDLE and drive `req_ready` = 0.
- EXEC:
  - The latched operands drive `_add32`; this is the settle cycle.
  - On the clock edge, register the adder output into `rsp_sum` and go to DONE.
  - `req_valid` is ignored.
- DONE:
  - `rsp_valid` = 1. `rsp_sum` and `rsp_id` hold stable until `rsp_ready` = 1.
  - On the edge where `rsp_ready` is high, go to IDLE.
  - No new grant is issued in that same cycle.
- Arbitration (round-robin build):
  - The search starts at `ptr+1` mod N and wraps around.
  - On a grant, `ptr` becomes g.
  - The reset value of `ptr` is N-1, so requester 0 wins first.
  - `ptr` is unchanged on cycles with no grant.
- Wrap-around: sums overflow silently. For example, 0xFFFFFFFF + 0x00000001 = 0x00000000.
- A requester that drops `req_valid` while not granted loses nothing. No request is queued.
- Reset asserted mid-transaction:
  - The in-flight operation is discarded with no response.
  - FSM → IDLE, `ptr` → N-1.
  - All outputs go to 0 immediately, without waiting for `clk`.

## Timing
- Output values during reset:
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_id` = 0, `rsp_sum` = 0, `busy` = 0.
- Latency: the grant in cycle T gives `rsp_valid` high in cycle T+2. The response stays high until it is accepted.
- Minimum spacing between grants is 3 cycles: grant, EXEC, and DONE with `rsp_ready` held high.
- `req_ready` depends combinationally on `req_valid`, the FSM state and `ptr`. Requesters must not make `req_valid` depend on `req_ready`.
- `rsp_valid`, `rsp_id` and `rsp_sum` are driven directly from flops. `busy` is decoded from the state.
- The settle budget is one full clock period for the 8-slice ripple chain. No other combinational path passes through the adder.

## Configuration
- `ADD32_ARB_RR_EN` defined:
  - Round-robin arbitration using `ptr`, as described above.
- `ADD32_ARB_RR_EN` undefined:
  - Fixed priority: the lowest index wins.
  - `ptr` is not built.
  - A continuously requesting requester 0 starves all others. This is accepted behaviour for this build.

## Test plan
- Single add: after reset, `req_valid` = 0001, a0 = 0x00000005, b0 = 0x00000007 → `req_ready` = 0001 in that cycle. Two cycles later `rsp_valid` = 1, `rsp_id` = 0, `rsp_sum` = 0x0000000C.
- Wrap-around: a1 = 0xFFFFFFFF, b1 = 0x00000001 → `rsp_sum` = 0x00000000, `rsp_id` = 1. Also a2 = 0x7FFFFFFF, b2 = 1 → 0x80000000.
- Fairness: `req_valid` = 1111 held constant with `rsp_ready` = 1.
  - Round-robin build: grant order 0,1,2,3,0,…
  - Fixed-priority build: grants are always 0.
- Backpressure: hold `rsp_ready` = 0 for 5 cycles in DONE → `rsp_valid`, `rsp_sum` and `rsp_id` stay stable and `req_ready` stays 0000. Releasing `rsp_ready` → IDLE on the next edge.
- Reset mid-op: deassert `rst_n` while in EXEC → all outputs go to 0 immediately. After release, `req_valid` = 0100 is granted to requester 2. With `req_valid` = 1111 instead, requester 0 wins, confirming `ptr` = N-1.

Source files
------------

// File: rtl/_add32_arbiter.sv
// _add32_arbiter: N valid/ready requesters share one 8-slice ripple adder, one op in flight.
// Define ADD32_ARB_RR_EN for round-robin arbitration; default build is fixed priority.

module _add32_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned ID_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N-1:0]      req_valid,
  output logic [N-1:0]      req_ready,
  input  logic [N*32-1:0]   req_a,
  input  logic [N*32-1:0]   req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output logic [31:0]       rsp_sum,
  output logic              busy
);

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [31:0]     sum_q, sum_d;
  logic            rsp_valid_q, rsp_valid_d;

  logic            grant_vld;
  logic [ID_W-1:0] grant_idx;
  logic            grant_fire;
  logic [31:0]     a_sel;
  logic [31:0]     b_sel;
  logic [31:0]     add_sum;

`ifdef ADD32_ARB_RR_EN
  logic [ID_W-1:0] ptr_q, ptr_d;

  // Search starts one past the last winner and wraps.
  always_comb begin
    logic [ID_W-1:0] cand;
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned off = 1; off <= N; off++) begin
      cand = ID_W'((32'(ptr_q) + off) % N);
      if (!grant_vld && req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (grant_fire) begin
      ptr_d = grant_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= ID_W'(N - 1);
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (!grant_vld && req_valid[i]) begin
        grant_vld = 1'b1;
        grant_idx = ID_W'(i);
      end
    end
  end
`endif

  // rst_n gates the grant so req_ready is 0 throughout reset, not only after the first edge.
  assign grant_fire = (state_q == StIdle) && grant_vld && rst_n;

  always_comb begin
    req_ready = '0;
    if (grant_fire) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_idx == ID_W'(i)) begin
        a_sel = req_a[i*32 +: 32];
        b_sel = req_b[i*32 +: 32];
      end
    end
  end

  _add32 u_add32 (
    .a_i   (a_q),
    .b_i   (b_q),
    .sum_o (add_sum)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    sum_d       = sum_q;
    rsp_valid_d = rsp_valid_q;
    unique case (state_q)
      StIdle: begin
        if (grant_fire) begin
          a_d     = a_sel;
          b_d     = b_sel;
          id_d    = grant_idx;
          state_d = StExec;
        end
      end
      StExec: begin
        // Operands have been stable for a full period; capture the settled ripple output.
        sum_d       = add_sum;
        rsp_valid_d = 1'b1;
        state_d     = StDone;
      end
      StDone: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      sum_q       <= '0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      sum_q       <= sum_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_sum   = sum_q;
  assign busy      = (state_q != StIdle);

endmodule

// 32-bit adder: eight 4-bit slices with carry rippling between them, carry-in tied low.
module _add32 (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] sum_o
);

  logic [8:0] carry;
  logic       unused_co;

  assign carry[0]  = 1'b0;
  assign unused_co = carry[8];

  for (genvar i = 0; i < 8; i++) begin : g_slice
    _74x283 u_slice (
      .a_i  (a_i[i*4 +: 4]),
      .b_i  (b_i[i*4 +: 4]),
      .c0_i (carry[i]),
      .s_o  (sum_o[i*4 +: 4]),
      .c4_o (carry[i+1])
    );
  end

endmodule

// 4-bit binary full adder with internal look-ahead carry, as in the 74x283.
module _74x283 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c0_i,
  output logic [3:0] s_o,
  output logic       c4_o
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  always_comb begin
    g    = a_i & b_i;
    p    = a_i ^ b_i;
    c[0] = c0_i;
    c[1] = g[0] | (p[0] & c0_i);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0_i);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0_i);
    c4_o = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & c0_i);
    s_o  = p ^ c;
  end

endmodule
